leaf_uplink_tx: RTL and testbench
=================================

Name: leaf_uplink_tx

Overview:
- Leaf-side transmitter for one spine uplink. Drives a spine router leaf port's `in_data`/`in_valid` pair.
- Packetizes local requests into a header flit plus 0..15 payload flits.
- Enforces credit-based flow control against the spine port's input FIFO, so the spine never drops a flit.
- One instance per leaf-to-spine link.

Parameters:
- GROUP_ID, 4'b0011, source group stamped into every header.
- LEAF_ID, 0, source leaf index (0..3) stamped into every header.
- DWIDTH, 16, flit width; fixed header layout requires 16.
- FIFO_DEPTH, 8, depth of the far-end input FIFO; initial and maximum credit count.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  packet request valid
- req_ready  out  1  request accepted when both valid and ready are high
- req_dest_group  in  4  destination group
- req_dest_leaf  in  2  destination leaf
- req_len  in  4  payload flit count, 0..15
- pay_data  in  DWIDTH  payload word
- pay_valid  in  1  payload word valid
- pay_ready  out  1  payload word consumed when both valid and ready are high
- link_out_data  out  DWIDTH  flit to spine port
- link_out_valid  out  1  flit valid, one-cycle qualifier
- link_credit_return  in  1  one pulse per flit drained from the far-end FIFO
- credits  out  clog2(FIFO_DEPTH+1)  current credit count
- err_credit_ovf  out  1  sticky: credit returned while already at FIFO_DEPTH
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert) forces these values:
  - FSM = IDLE
  - credits = FIFO_DEPTH
  - link_out_data = 0, link_out_valid = 0
  - err_credit_ovf = 0, busy = 0
  - internal length and remaining registers = 0
- Header flit layout:
  - [15:12] dest group
  - [11:10] dest leaf
  - [9:8] LEAF_ID[1:0]
  - [7:4] GROUP_ID
  - [3:0] len
  - Bits [15:10] form the 6-bit routing address the spine decodes.
- credit_ok = (credits != 0). It is evaluated on the registered count; a same-cycle return does not create a credit.
- FSM states:
  - IDLE:
    - req_ready = 1.
    - On handshake: latch dest group, dest leaf and len; go to HDR.
  - HDR:
    - req_ready = 0.
    - If credit_ok: next cycle link_out_data = header and link_out_valid = 1; consume one credit.
    - If len == 0, go to IDLE; otherwise set remaining = len and go to BODY.
    - If no credit: hold in HDR with link_out_valid = 0.
  - BODY:
    - pay_ready = credit_ok (combinational); pay_ready = 0 in every other state.
    - On payload handshake: next cycle link_out_data = pay_data and link_out_valid = 1; consume one credit; decrement remaining.
    - When the handshake occurs with remaining == 1, go to IDLE.
- Output timing:
  - Outputs are registered: each flit appears exactly one cycle after its handshake or credit decision.
  - Back-to-back flits are permitted every cycle while credits last.
  - Minimum packet cost: 1 request cycle + (len+1) flit cycles.
  - link_out_valid drops to 0 in any cycle with no flit issued. link_out_data holds its last value when not valid.
- Credit arithmetic (one cycle, not two):
  - Consume and return in the same cycle: net 0.
  - Return only: +1, saturating at FIFO_DEPTH. A return at FIFO_DEPTH sets err_credit_ovf; only reset clears it.
  - Consume only: -1. Consume is never attempted at 0 because of credit_ok gating.
- Boundaries:
  - credits == 0 mid-packet: stall in BODY; flit order and the remaining count are preserved.
  - len == 15: exactly 16 flits are sent.
  - pay_valid is ignored outside BODY. req_valid is ignored outside IDLE.
  - Reset mid-packet: packet is abandoned; credits are restored to FIFO_DEPTH (the far end is reset together with this block).

Optional Feature:
- Macro: UPLINK_STATS_EN.
- When defined:
  - Adds outputs tx_flit_count[15:0] and stall_count[15:0], both reset to 0.
  - tx_flit_count increments on every cycle with link_out_valid = 1.
  - stall_count increments on every cycle in HDR or BODY with credits == 0.
  - Both counters wrap modulo 2^16.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then request dest_group = 5, dest_leaf = 2, len = 0 (LEAF_ID = 1, GROUP_ID = 3) -> single flit 16'h5930 with valid high for 1 cycle; credits 8 -> 7; back to IDLE.
- len = 3 with payloads AAAA, BBBB, CCCC streamed each cycle, no credit returns -> flits header, AAAA, BBBB, CCCC on 4 consecutive cycles; credits = 4.
- FIFO_DEPTH = 8, len = 15, no returns -> 8 flits sent, pay_ready low, valid low; one credit return pulse -> exactly one more flit; eventually all 16 flits in order.
- credits = 0 with a credit return in the same cycle as a pending BODY word -> no flit that cycle; flit issued the following cycle; credits end at 0.
- Extra credit return at credits = 8 -> credits stay 8; err_credit_ovf = 1 and stays set until reset.
- Assert reset (low) in the middle of a len = 5 packet -> all outputs at reset values within the same cycle; credits = 8; no further flits of that packet after release.

Source files
------------

// File: rtl/leaf_uplink_tx.sv
// Leaf-to-spine uplink transmitter: packetizes requests into header + payload flits under credit flow control.
// Optional `UPLINK_STATS_EN adds tx_flit_count_o / stall_count_o activity counters.
module leaf_uplink_tx #(
  parameter logic [3:0] GROUP_ID   = 4'b0011,
  parameter int         LEAF_ID    = 0,
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  localparam int        CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_dest_group_i,
  input  logic [1:0]        req_dest_leaf_i,
  input  logic [3:0]        req_len_i,
  input  logic [DWIDTH-1:0] pay_data_i,
  input  logic              pay_valid_i,
  output logic              pay_ready_o,
  output logic [DWIDTH-1:0] link_out_data_o,
  output logic              link_out_valid_o,
  input  logic              link_credit_return_i,
  output logic [CW-1:0]     credits_o,
`ifdef UPLINK_STATS_EN
  output logic [15:0]       tx_flit_count_o,
  output logic [15:0]       stall_count_o,
`endif
  output logic              err_credit_ovf_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_e;

  typedef struct packed {
    logic [3:0] grp;
    logic [1:0] leaf;
    logic [3:0] len;
  } req_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [1:0]    LEAF_C  = 2'(LEAF_ID);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [3:0]        rem_q, rem_d;
  logic [CW-1:0]     cred_q, cred_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              vld_q, vld_d;
  logic              ovf_q, ovf_d;
  logic              consume, credit_ok;
  logic [15:0]       hdr;

  // Gating uses the registered count only; a return this cycle cannot fund a flit this cycle.
  assign credit_ok = (cred_q != '0);
  assign hdr       = {req_q.grp, req_q.leaf, LEAF_C, GROUP_ID, req_q.len};

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rem_d       = rem_q;
    data_d      = data_q;
    vld_d       = 1'b0;
    consume     = 1'b0;
    req_ready_o = 1'b0;
    pay_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          req_d   = '{grp: req_dest_group_i, leaf: req_dest_leaf_i, len: req_len_i};
          state_d = HDR;
        end
      end
      HDR: begin
        if (credit_ok) begin
          data_d  = DWIDTH'(hdr);
          vld_d   = 1'b1;
          consume = 1'b1;
          if (req_q.len == 4'd0) begin
            state_d = IDLE;
          end else begin
            rem_d   = req_q.len;
            state_d = BODY;
          end
        end
      end
      BODY: begin
        pay_ready_o = credit_ok;
        if (pay_valid_i && credit_ok) begin
          data_d  = pay_data_i;
          vld_d   = 1'b1;
          consume = 1'b1;
          rem_d   = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Consume and return in one cycle cancel; a lone return at full count is an overflow.
  always_comb begin
    cred_d = cred_q;
    ovf_d  = ovf_q;
    if (consume && !link_credit_return_i) begin
      cred_d = cred_q - CW'(1);
    end else if (!consume && link_credit_return_i) begin
      if (cred_q == DEPTH_C) ovf_d = 1'b1;
      else                   cred_d = cred_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      rem_q   <= '0;
      cred_q  <= DEPTH_C;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rem_q   <= rem_d;
      cred_q  <= cred_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef UPLINK_STATS_EN
  logic [15:0] txc_q, stc_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      txc_q <= '0;
      stc_q <= '0;
    end else begin
      if (vld_q) txc_q <= txc_q + 16'd1;
      if ((state_q != IDLE) && !credit_ok) stc_q <= stc_q + 16'd1;
    end
  end

  assign tx_flit_count_o = txc_q;
  assign stall_count_o   = stc_q;
`endif

  assign link_out_data_o  = data_q;
  assign link_out_valid_o = vld_q;
  assign credits_o        = cred_q;
  assign err_credit_ovf_o = ovf_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_leaf_uplink_tx.sv
// Bench for leaf_uplink_tx: expected flit stream and credit count come from a packet/credit-ledger model.
module tb_leaf_uplink_tx;
  localparam int         DEPTH = 8;
  localparam int         CW    = 4;
  localparam logic [3:0] GRP   = 4'h3;
  localparam int         LEAF  = 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [3:0]    req_grp = '0, req_len = '0;
  logic [1:0]    req_leaf = '0;
  logic [15:0]   pay_data = '0;
  logic          pay_valid = 1'b0, pay_ready;
  logic [15:0]   out_data;
  logic          out_valid, ret = 1'b0, err, busy;
  logic [CW-1:0] credits;
`ifdef UPLINK_STATS_EN
  logic [15:0]   txc, stc;
`endif

  int nasrt = 0, nfail = 0, cyc = 0, cm = DEPTH, hs_cyc = 0;
  bit ovf_m = 1'b0, pkt_to = 1'b0;
  logic [15:0] exp_q[$], obs_q[$], pay_w[$];
  int obs_t[$];

  leaf_uplink_tx #(.GROUP_ID(GRP), .LEAF_ID(LEAF), .DWIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dest_group_i(req_grp), .req_dest_leaf_i(req_leaf), .req_len_i(req_len),
    .pay_data_i(pay_data), .pay_valid_i(pay_valid), .pay_ready_o(pay_ready),
    .link_out_data_o(out_data), .link_out_valid_o(out_valid),
    .link_credit_return_i(ret), .credits_o(credits),
`ifdef UPLINK_STATS_EN
    .tx_flit_count_o(txc), .stall_count_o(stc),
`endif
    .err_credit_ovf_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Monitor: records every flit with its cycle and keeps a credit ledger (sent minus returned).
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cm = DEPTH; ovf_m = 1'b0;
    end else begin
      cyc++;
      #1;
      if (out_valid === 1'b1) begin obs_q.push_back(out_data); obs_t.push_back(cyc); cm--; end
      if (ret) cm++;
      if (cm > DEPTH) begin cm = DEPTH; ovf_m = 1'b1; end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_words(input int n);
    pay_w.delete();
    for (int k = 0; k < n; k++) pay_w.push_back(16'($urandom));
  endtask

  task automatic restore_credits();
    for (int k = 0; k < 40 && cm < DEPTH; k++) begin ret = 1'b1; @(negedge clk); end
    ret = 1'b0;
  endtask

  task automatic clear_q();
    exp_q.delete(); obs_q.delete(); obs_t.delete();
  endtask

  // Sends one packet using pay_w as payload; gap = percent chance of idling pay_valid.
  task automatic send_pkt(input logic [3:0] g, input logic [1:0] l, input logic [3:0] len,
                          input int gap, input int budget);
    int i = 0, n = 0;
    bit hs;
    exp_q.push_back({g, l, 2'(LEAF), GRP, len});
    for (int k = 0; k < int'(len); k++) exp_q.push_back(pay_w[k]);
    @(negedge clk);
    req_valid = 1'b1; req_grp = g; req_leaf = l; req_len = len;
    while (req_ready !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    hs_cyc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0; req_grp = 4'($urandom); req_len = 4'($urandom);
    while (i < int'(len) && n < budget && rst_n) begin
      pay_valid = ($urandom_range(99) >= gap);
      pay_data  = pay_valid ? pay_w[i] : 16'($urandom);
      hs = pay_valid && (pay_ready === 1'b1);
      @(negedge clk); n++;
      if (hs) i++;
    end
    pay_valid = 1'b0;
    if (n >= budget) pkt_to = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(3);
    nasrt++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    nasrt++; if (out_data !== 16'h0) begin nfail++; $display("FAIL reset_data got %h want 0000", out_data); end
    nasrt++; if (credits !== CW'(DEPTH)) begin nfail++; $display("FAIL reset_credits got %0d want %0d", credits, DEPTH); end
    nasrt++; if (err !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL reset_err_busy got %b%b want 00", err, busy); end
    nasrt++; if (req_ready !== 1'b1 || pay_ready !== 1'b0) begin nfail++; $display("FAIL reset_ready got %b%b want 10", req_ready, pay_ready); end
    rst_n = 1'b1; idle(2);
  endtask

  task automatic test_single_header();
    clear_q(); pay_w.delete();
    send_pkt(4'd5, 2'd2, 4'd0, 0, 50); idle(3);
    nasrt++; if (obs_q.size() != 1) begin nfail++; $display("FAIL single_count got %0d want 1", obs_q.size()); end
    else begin
      nasrt++; if (obs_q[0] !== 16'h5930) begin nfail++; $display("FAIL single_hdr got %h want 5930", obs_q[0]); end
      nasrt++; if (obs_t[0] != hs_cyc + 1) begin nfail++; $display("FAIL single_latency got %0d want %0d", obs_t[0], hs_cyc + 1); end
    end
    nasrt++; if (credits !== CW'(7)) begin nfail++; $display("FAIL single_credits got %0d want 7", credits); end
    nasrt++; if (busy !== 1'b0) begin nfail++; $display("FAIL single_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    restore_credits(); clear_q();
    pay_w = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    send_pkt(4'd9, 2'd1, 4'd3, 0, 50); idle(3);
    nasrt++; if (obs_q.size() != 4) begin nfail++; $display("FAIL b2b_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      nasrt++; if (obs_q[i] !== exp_q[i]) begin nfail++; $display("FAIL b2b_flit%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      nasrt++; if (obs_t[i] != hs_cyc + 1 + i) begin nfail++; $display("FAIL b2b_time%0d got %0d want %0d", i, obs_t[i], hs_cyc + 1 + i); end
    end
    nasrt++; if (credits !== CW'(4)) begin nfail++; $display("FAIL b2b_credits got %0d want 4", credits); end
  endtask

  task automatic test_credit_stall();
    bit done = 1'b0;
    restore_credits(); clear_q(); rand_words(15);
    fork begin send_pkt(4'd12, 2'd3, 4'd15, 0, 400); done = 1'b1; end join_none
    idle(20);
    nasrt++; if (obs_q.size() != DEPTH) begin nfail++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), DEPTH); end
    nasrt++; if (pay_ready !== 1'b0 || out_valid !== 1'b0) begin nfail++; $display("FAIL stall_ready_valid got %b%b want 00", pay_ready, out_valid); end
    nasrt++; if (credits !== CW'(0) || busy !== 1'b1) begin nfail++; $display("FAIL stall_credits_busy got %0d/%b want 0/1", credits, busy); end
    ret = 1'b1; @(negedge clk); ret = 1'b0; idle(4);
    nasrt++; if (obs_q.size() != DEPTH + 1) begin nfail++; $display("FAIL stall_one_more got %0d want %0d", obs_q.size(), DEPTH + 1); end
    for (int k = 0; k < 200 && !(done && cm == DEPTH); k++) begin ret = (cm < DEPTH); @(negedge clk); end
    ret = 1'b0;
    nasrt++; if (!done || pkt_to) begin nfail++; $display("FAIL stall_timeout got done=%b to=%b want 1/0", done, pkt_to); end
    nasrt++; if (obs_q.size() != 16) begin nfail++; $display("FAIL stall_total got %0d want 16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      nasrt++; if (obs_q[i] !== exp_q[i]) begin nfail++; $display("FAIL stall_flit%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_credit_race();
    bit done = 1'b0;
    int e;
    restore_credits(); clear_q(); rand_words(9);
    fork begin send_pkt(4'd2, 2'd0, 4'd9, 0, 200); done = 1'b1; end join_none
    idle(15);
    nasrt++; if (obs_q.size() != DEPTH) begin nfail++; $display("FAIL race_pre got %0d want %0d", obs_q.size(), DEPTH); end
    ret = 1'b1; e = cyc + 1; @(negedge clk); ret = 1'b0;
    nasrt++; if (obs_q.size() != DEPTH) begin nfail++; $display("FAIL race_same_cycle got %0d flits want %0d", obs_q.size(), DEPTH); end
    nasrt++; if (credits !== CW'(1)) begin nfail++; $display("FAIL race_credit_up got %0d want 1", credits); end
    @(negedge clk);
    nasrt++; if (obs_q.size() != DEPTH + 1 || obs_t[obs_t.size()-1] != e + 1) begin
      nfail++; $display("FAIL race_next_cycle got n=%0d t=%0d want n=%0d t=%0d", obs_q.size(), obs_t[obs_t.size()-1], DEPTH + 1, e + 1);
    end
    ret = 1'b1; @(negedge clk); ret = 1'b0; idle(3);
    nasrt++; if (!done || pkt_to) begin nfail++; $display("FAIL race_timeout got done=%b to=%b want 1/0", done, pkt_to); end
    nasrt++; if (credits !== CW'(0)) begin nfail++; $display("FAIL race_end_credits got %0d want 0", credits); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      nasrt++; if (obs_q[i] !== exp_q[i]) begin nfail++; $display("FAIL race_flit%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    restore_credits(); clear_q();
    nasrt++; if (err !== 1'b0) begin nfail++; $display("FAIL ovf_pre got %b want 0", err); end
    ret = 1'b1; @(negedge clk); ret = 1'b0; idle(2);
    nasrt++; if (credits !== CW'(DEPTH)) begin nfail++; $display("FAIL ovf_credits got %0d want %0d", credits, DEPTH); end
    nasrt++; if (err !== 1'b1) begin nfail++; $display("FAIL ovf_set got %b want 1", err); end
    pay_w.delete(); send_pkt(4'd1, 2'd1, 4'd0, 0, 50); idle(4);
    nasrt++; if (err !== 1'b1 || credits !== CW'(DEPTH - 1)) begin nfail++; $display("FAIL ovf_sticky got %b/%0d want 1/%0d", err, credits, DEPTH - 1); end
  endtask

  task automatic test_reset_mid_packet();
    bit done = 1'b0;
    int n0;
    restore_credits(); clear_q(); rand_words(5);
    fork begin send_pkt(4'd7, 2'd2, 4'd5, 0, 100); done = 1'b1; end join_none
    for (int k = 0; k < 20 && obs_q.size() < 3; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nasrt++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin nfail++; $display("FAIL rmid_out got %b/%h want 0/0000", out_valid, out_data); end
    nasrt++; if (credits !== CW'(DEPTH) || busy !== 1'b0 || err !== 1'b0) begin
      nfail++; $display("FAIL rmid_state got cred=%0d busy=%b err=%b want %0d/0/0", credits, busy, err, DEPTH);
    end
    n0 = obs_q.size();
    idle(2); rst_n = 1'b1;
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    idle(10);
    nasrt++; if (obs_q.size() != n0 || busy !== 1'b0) begin nfail++; $display("FAIL rmid_abandon got n=%0d busy=%b want n=%0d busy=0", obs_q.size(), busy, n0); end
    nasrt++; if (credits !== CW'(DEPTH)) begin nfail++; $display("FAIL rmid_credits got %0d want %0d", credits, DEPTH); end
    pkt_to = 1'b0;
  endtask

  task automatic test_random_traffic();
    bit rdone = 1'b0;
    restore_credits(); clear_q();
    fork
      begin
        for (int p = 0; p < 6; p++) begin
          logic [3:0] ln = 4'($urandom);
          rand_words(int'(ln));
          send_pkt(4'($urandom), 2'($urandom), ln, 30, 400);
          idle($urandom_range(2));
        end
        rdone = 1'b1;
      end
      begin
        for (int k = 0; k < 3000 && !rdone; k++) begin
          ret = (cm < DEPTH) && ($urandom_range(1) == 1);
          @(negedge clk);
        end
        ret = 1'b0;
      end
    join
    ret = 1'b0; idle(4);
    nasrt++; if (!rdone || pkt_to) begin nfail++; $display("FAIL rand_timeout got done=%b to=%b want 1/0", rdone, pkt_to); end
    nasrt++; if (obs_q.size() != exp_q.size()) begin nfail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      nasrt++; if (obs_q[i] !== exp_q[i]) begin nfail++; $display("FAIL rand_flit%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    nasrt++; if (credits !== CW'(cm)) begin nfail++; $display("FAIL rand_credits got %0d want %0d", credits, cm); end
    nasrt++; if (err !== ovf_m) begin nfail++; $display("FAIL rand_err got %b want %b", err, ovf_m); end
  endtask

  initial begin
    test_reset();
    test_single_header();
    test_back_to_back();
    test_credit_stall();
    test_credit_race();
    test_overflow();
    test_reset_mid_packet();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end
endmodule
